cpu_fetch_queue: RTL and testbench
==================================

// Module: cpu_fetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage for the pipelined CPU: owns the PC, requests
//  instructions from instruction memory, buffers them in a DEPTH-entry prefetch queue
//  and presents {pc, ir} to the decode (ID) stage with a valid/ready handshake.
//  Adds what the single-register IF stage lacked: prefetch, back-pressure, redirect-flush (JMP/JMPR/branch), halt/restart.
// PARAMETERS
//  ADDR_W    8     instruction address / PC width; PC wraps modulo 2**ADDR_W
//  INSTR_W   16    instruction word width
//  DEPTH     4     prefetch queue entries; power of two, >= 2
//  RESET_PC  0     PC value loaded by reset
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  enable     in   1        global advance; 0 freezes all state
//  start      in   1        begin fetching (IDLE/HALTED -> RUN)
//  halt_req   in   1        stop fetching (decoded HALT); queue keeps draining
//  redir_valid in  1        control-flow redirect from EX
//  redir_pc   in   ADDR_W   redirect target
//  i_addr     out  ADDR_W   fetch address (= PC register)
//  i_req      out  1        fetch request
//  i_ack      in   1        memory accepts; i_datain valid same cycle
//  i_datain   in   INSTR_W  instruction word
//  id_valid   out  1        queue head valid
//  id_ready   in   1        ID stage consumes head
//  id_ir      out  INSTR_W  head instruction
//  id_pc      out  ADDR_W   head instruction address
//  q_count    out  clog2(DEPTH+1) occupancy
//  running    out  1        state == RUN
// BEHAVIOUR
//  - Reset: state IDLE, PC=RESET_PC, queue empty, all storage 0; so i_addr=RESET_PC,
//    i_req=0, id_valid=0, id_ir=0, id_pc=0, q_count=0, running=0.
//  - Priority each edge: reset > !enable (hold all, i_req=0, no pop) > redirect > halt_req > start > normal.
//  - FSM: IDLE --start--> RUN; RUN --halt_req--> HALTED; HALTED --start--> RUN.
//    start in RUN ignored; halt_req in IDLE/HALTED ignored.
//  - i_req = running & enable & !redir_valid & !halt_req & (q_count < DEPTH). No fall-through
//    push when full, even if head popped same cycle.
//  - Push on i_req & i_ack: entry {PC, i_datain}; PC <= PC+1 (ADDR_W wrap, 2**ADDR_W-1 -> 0).
//    i_req without i_ack: PC held, retried next cycle.
//  - Pop on enable & id_valid & id_ready. Push and pop same cycle: q_count unchanged.
//  - Latency: word acked in cycle N visible on id_ir/id_pc in N+1 (if queue empty). Throughput 1/cycle.
//  - id_ir/id_pc reflect head entry; when empty they hold last-read value, id_valid=0.
//  - Redirect (enable=1): queue flushed (q_count=0, pointers 0), PC <= redir_pc, no fetch that
//    cycle; a pop the same cycle counts as delivered, entry discarded with the flush.
//    Redirect in IDLE/HALTED loads PC, state unchanged.
//  - Redirect + halt_req same cycle: flush+PC load performed, state -> HALTED.
//  - HALTED: no requests; remaining entries drain normally; start resumes from current PC.
//  - reset asserted mid-operation: reset values above next edge, regardless of enable.
// STRUCTURE
//  - Shared include cpu_defs.vh: FSM state encodings (IDLE/RUN/HALTED), opcode constants
//    already used by the CPU (NOP, HALT, JMP, JMPR, ...).
//  - Sub-module cpu_sync_fifo (WIDTH=ADDR_W+INSTR_W, DEPTH; push/pop/flush, count, full/empty);
//    top level holds PC, FSM, request and redirect logic.
// TESTING
//  - Reset, start, i_ack=1, id_ready=1, words A0..A3 -> id_pc 00,01,02,03 one per cycle, 1 cycle after ack.
//  - id_ready=0, i_ack=1 from start -> exactly DEPTH pushes (PC 00..03), q_count=4, i_req=0, i_addr=04 held.
//  - Queue holds 3 entries, redir_valid with redir_pc=0x20 -> next cycle q_count=0, id_valid=0,
//    i_addr=0x20; first subsequent id_pc=0x20.
//  - halt_req with 2 entries queued -> running=0, i_req=0, both entries drained, then start
//    resumes fetch at saved PC; PC 0xFF with ADDR_W=8 wraps to 0x00 after push.
//  - enable=0 for 3 cycles mid-stream -> PC, q_count, outputs frozen; reset=1 while RUN with
//    queue full -> IDLE, q_count=0, i_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/cpu_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM state encoding.
package cpu_fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_queue_fifo.sv
// Synchronous prefetch FIFO with flush; the head entry is kept in a register so it
// holds its last value while the queue is empty.
module cpu_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_nxt_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign push_ok_s = push_i & ~full_o & ~flush_i;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign rd_nxt_s  = rd_ptr_q + PTR_W'(1);
    assign head_o    = head_q;
    assign count_o   = count_q;

    // Next pointers, occupancy and head register; the head preloads the entry behind a pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (pop_ok_s)  rd_ptr_d = rd_nxt_s;
            else           rd_ptr_d = rd_ptr_q;
            if (push_ok_s && !pop_ok_s)      count_d = count_q + CNT_W'(1);
            else if (!push_ok_s && pop_ok_s) count_d = count_q - CNT_W'(1);
            else                             count_d = count_q;
            if (pop_ok_s && (count_q > CNT_W'(1)))
                head_d = mem_q[rd_nxt_s];
            else if (push_ok_s && (empty_o || pop_ok_s))
                head_d = wdata_i;
            else
                head_d = head_q;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (push_ok_s) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/cpu_fetch_queue.sv
// Instruction-fetch stage: PC, fetch FSM, memory request and redirect handling in front
// of a prefetch queue feeding decode.
module cpu_fetch_queue
    import cpu_fetch_queue_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          INSTR_W  = 16,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       start,
    input  logic                       halt_req,
    input  logic                       redir_valid,
    input  logic [ADDR_W-1:0]          redir_pc,
    output logic [ADDR_W-1:0]          i_addr,
    output logic                       i_req,
    input  logic                       i_ack,
    input  logic [INSTR_W-1:0]         i_datain,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [INSTR_W-1:0]         id_ir,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       running
);
    fetch_state_e               state_q;
    logic [ADDR_W-1:0]          pc_q;
    logic                       req_s, push_s, pop_s, flush_s;
    logic                       full_s, empty_s;
    logic [ADDR_W+INSTR_W-1:0]  head_s;

    // No request on a redirect or halt cycle, and never into a full queue even if it pops.
    assign req_s   = (state_q == ST_RUN) & enable & ~redir_valid & ~halt_req & ~full_s;
    assign push_s  = req_s & i_ack;
    assign pop_s   = enable & ~empty_s & id_ready;
    assign flush_s = enable & redir_valid;

    assign i_req    = req_s;
    assign i_addr   = pc_q;
    assign running  = (state_q == ST_RUN);
    assign id_valid = ~empty_s;
    assign id_pc    = head_s[ADDR_W+INSTR_W-1:INSTR_W];
    assign id_ir    = head_s[INSTR_W-1:0];

    cpu_sync_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .wdata_i ({pc_q, i_datain}),
        .head_o  (head_s),
        .count_o (q_count),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Fetch FSM and program counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
        end else if (enable) begin
            if (redir_valid) begin
                pc_q <= redir_pc;
                if (halt_req && (state_q == ST_RUN)) state_q <= ST_HALTED;
                else                                  state_q <= state_q;
            end else begin
                if (push_s) pc_q <= pc_q + ADDR_W'(1);
                else        pc_q <= pc_q;
                case (state_q)
                    ST_IDLE, ST_HALTED: begin
                        if (start && !halt_req) state_q <= ST_RUN;
                        else                    state_q <= state_q;
                    end
                    ST_RUN: begin
                        if (halt_req) state_q <= ST_HALTED;
                        else          state_q <= ST_RUN;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end else begin
            state_q <= state_q;
            pc_q    <= pc_q;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Randomised scoreboard bench for cpu_fetch_queue against a queue-based reference model.
module tb_cpu_fetch_queue;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;

    logic                 clock = 1'b0;
    logic                 reset, enable, start, halt_req, redir_valid, i_ack, id_ready;
    logic [ADDR_W-1:0]    redir_pc;
    logic [INSTR_W-1:0]   i_datain;
    logic [ADDR_W-1:0]    i_addr, id_pc;
    logic [INSTR_W-1:0]   id_ir;
    logic                 i_req, id_valid, running;
    logic [2:0]           q_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: run flag, PC and the ordered list of fetched {pc, ir} not yet delivered.
    bit                          m_run = 1'b0;
    logic [ADDR_W-1:0]           m_pc  = '0;
    logic [ADDR_W+INSTR_W-1:0]   sb[$];

    cpu_fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .halt_req(halt_req),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .i_addr(i_addr), .i_req(i_req),
        .i_ack(i_ack), .i_datain(i_datain), .id_valid(id_valid), .id_ready(id_ready),
        .id_ir(id_ir), .id_pc(id_pc), .q_count(q_count), .running(running)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: check state outputs, then apply the coming clock edge.
    initial begin
        bit exp_req, exp_push;
        forever begin
            @(negedge clock);
            exp_req = enable && m_run && !redir_valid && !halt_req && (sb.size() < DEPTH);
            exp_push = exp_req && i_ack;
            chk("running", 32'(running), 32'(m_run));
            chk("q_count", 32'(q_count), 32'(sb.size()));
            chk("id_valid", 32'(id_valid), 32'(sb.size() != 0));
            chk("i_addr", 32'(i_addr), 32'(m_pc));
            chk("i_req", 32'(i_req), 32'(exp_req));
            #3;
            if (reset) begin
                m_run = 1'b0;
                m_pc  = '0;
                sb.delete();
            end else if (enable) begin
                if (exp_push) begin
                    sb.push_back({m_pc, i_datain});
                    m_pc = ADDR_W'((int'(m_pc) + 1) % (1 << ADDR_W));
                end
                if (redir_valid) begin
                    sb.delete();
                    m_pc = redir_pc;
                    if (halt_req) m_run = 1'b0;
                end else if (halt_req) begin
                    m_run = 1'b0;
                end else if (start) begin
                    m_run = 1'b1;
                end
            end
        end
    end

    // Monitor: every handshake at decode must deliver the oldest expected fetch.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset && enable && id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL head_unexpected: got %0h expected none at %0t", {id_pc, id_ir}, $time);
                end else begin
                    chk("head", 32'({id_pc, id_ir}), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit en, input bit st, input bit hr, input bit rv,
                         input logic [ADDR_W-1:0] rpc, input bit ack, input bit rdy, input int n);
        for (int k = 0; k < n; k++) begin
            enable = en; start = st; halt_req = hr; redir_valid = rv;
            redir_pc = rpc; i_ack = ack; id_ready = rdy;
            i_datain = INSTR_W'($urandom);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; start = 1'b0; halt_req = 1'b0; redir_valid = 1'b0;
        redir_pc = '0; i_ack = 1'b0; id_ready = 1'b0; i_datain = '0;
        drive(1, 0, 0, 0, 8'h00, 0, 0, 2);
        chk("reset_id_ir", 32'(id_ir), 32'h0);
        chk("reset_id_pc", 32'(id_pc), 32'h0);
        chk("reset_i_addr", 32'(i_addr), 32'h0);
        reset = 1'b0;

        drive(1, 1, 0, 0, 8'h00, 0, 1, 1);
        drive(1, 0, 0, 0, 8'h00, 1, 1, 6);
        drive(1, 0, 0, 0, 8'h00, 0, 1, 3);

        drive(1, 0, 0, 1, 8'h00, 0, 0, 1);
        drive(1, 0, 0, 0, 8'h00, 1, 0, 6);
        chk("full_q_count", 32'(q_count), 32'd4);
        chk("full_i_req", 32'(i_req), 32'd0);
        chk("full_i_addr", 32'(i_addr), 32'h04);

        drive(1, 0, 0, 0, 8'h00, 0, 1, 1);
        drive(1, 0, 0, 1, 8'h20, 0, 0, 1);
        chk("redir_q_count", 32'(q_count), 32'd0);
        chk("redir_i_addr", 32'(i_addr), 32'h20);
        drive(1, 0, 0, 0, 8'h00, 1, 1, 3);

        drive(1, 0, 0, 0, 8'h00, 0, 1, 4);
        drive(1, 0, 0, 0, 8'h00, 1, 0, 2);
        drive(1, 0, 1, 0, 8'h00, 1, 0, 1);
        chk("halt_running", 32'(running), 32'd0);
        drive(1, 0, 0, 0, 8'h00, 1, 1, 4);
        drive(1, 1, 0, 0, 8'h00, 0, 1, 1);
        drive(1, 0, 0, 0, 8'h00, 1, 1, 3);

        drive(1, 0, 0, 1, 8'hFE, 0, 1, 1);
        drive(1, 0, 0, 0, 8'h00, 1, 1, 2);
        chk("wrap_i_addr", 32'(i_addr), 32'h00);
        drive(1, 0, 0, 0, 8'h00, 1, 1, 2);

        drive(1, 0, 0, 0, 8'h00, 1, 1, 2);
        drive(0, 1, 0, 1, 8'h55, 1, 1, 3);
        drive(1, 0, 0, 0, 8'h00, 1, 1, 2);

        drive(1, 0, 0, 0, 8'h00, 1, 0, 5);
        reset = 1'b1;
        drive(0, 0, 0, 0, 8'h00, 1, 0, 1);
        reset = 1'b0;
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_i_addr", 32'(i_addr), 32'h00);
        chk("rst_running", 32'(running), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom % 200) == 0;
            drive(($urandom % 10) != 0, ($urandom % 8) == 0, ($urandom % 20) == 0,
                  ($urandom % 25) == 0, ADDR_W'($urandom), ($urandom % 3) != 0,
                  ($urandom % 3) != 0, 1);
        end
        reset = 1'b0;
        drive(1, 0, 0, 0, 8'h00, 0, 1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
